// File: rtl/wb_bram_arbiter.sv
// Two-master Wishbone arbiter in front of a single wb_bram slave.
// Round-robin per bus cycle, with stalled-slave abort after TIMEOUT_CYCLES.
module wb_bram_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_m0_we,
  input  logic        i_m0_stb,
  input  logic        i_m0_cyc,
  input  logic [3:0]  i_m0_sel,
  input  logic [31:0] i_m0_adr,
  input  logic [31:0] i_m0_dat,
  output logic [31:0] o_m0_dat,
  output logic        o_m0_ack,
  output logic        o_m0_int,
  input  logic        i_m1_we,
  input  logic        i_m1_stb,
  input  logic        i_m1_cyc,
  input  logic [3:0]  i_m1_sel,
  input  logic [31:0] i_m1_adr,
  input  logic [31:0] i_m1_dat,
  output logic [31:0] o_m1_dat,
  output logic        o_m1_ack,
  output logic        o_m1_int,
  output logic        o_s_we,
  output logic        o_s_stb,
  output logic        o_s_cyc,
  output logic [3:0]  o_s_sel,
  output logic [31:0] o_s_adr,
  output logic [31:0] o_s_dat,
  input  logic [31:0] i_s_dat,
  input  logic        i_s_ack,
  input  logic        i_s_int,
  output logic [1:0]  o_grant,
  output logic        o_timeout
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} state_t;

  typedef struct packed {
    logic        we;
    logic        stb;
    logic        cyc;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_req_t;

  state_t        state;
  logic          last;  // master that owned the bus most recently
  logic          own;   // current owner, kept through ABORT
  logic [CW-1:0] cnt;
  wb_req_t       req0, req1, req_x;
  logic          in_gnt, timeout_hit;

  assign req0  = {i_m0_we, i_m0_stb, i_m0_cyc, i_m0_sel, i_m0_adr, i_m0_dat};
  assign req1  = {i_m1_we, i_m1_stb, i_m1_cyc, i_m1_sel, i_m1_adr, i_m1_dat};
  assign req_x = own ? req1 : req0;

  assign in_gnt      = (state == GNT0) || (state == GNT1);
  // An ack on the threshold cycle completes the transfer instead of aborting it.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && in_gnt && req_x.stb && !i_s_ack &&
                       (cnt == CNT_LAST);
  assign o_timeout   = timeout_hit;

  assign o_m0_int = i_s_int;
  assign o_m1_int = i_s_int;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
      own   <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (i_m0_cyc && (!i_m1_cyc || last)) begin
            state <= GNT0;
            own   <= 1'b0;
          end else if (i_m1_cyc) begin
            state <= GNT1;
            own   <= 1'b1;
          end
        end
        GNT0, GNT1: begin
          if (!req_x.cyc) begin
            state <= IDLE;
            last  <= own;
            cnt   <= '0;
          end else if (timeout_hit) begin
            state <= ABORT;
            cnt   <= '0;
          end else if (!req_x.stb || i_s_ack) begin
            cnt <= '0;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        ABORT: begin
          cnt <= '0;
          if (!req_x.stb) begin
            state <= IDLE;
            last  <= own;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    {o_s_we, o_s_stb, o_s_cyc, o_s_sel, o_s_adr, o_s_dat} = '0;
    o_m0_ack = 1'b0;
    o_m1_ack = 1'b0;
    o_m0_dat = '0;
    o_m1_dat = '0;
    o_grant  = 2'b00;
    case (state)
      GNT0, GNT1: begin
        {o_s_we, o_s_stb, o_s_cyc, o_s_sel, o_s_adr, o_s_dat} = req_x;
        o_grant = own ? 2'b10 : 2'b01;
        if (own) begin
          o_m1_ack = i_s_ack;
          o_m1_dat = i_s_dat;
        end else begin
          o_m0_ack = i_s_ack;
          o_m0_dat = i_s_dat;
        end
      end
      ABORT: begin
        // Slave is cut off; the owner gets a dataless ack to close its strobe.
        o_grant = own ? 2'b10 : 2'b01;
        if (own) o_m1_ack = req_x.stb;
        else     o_m0_ack = req_x.stb;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_bram_arbiter.sv
// Directed bench for wb_bram_arbiter with a behavioural wb_bram slave model.
module tb_wb_bram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        m_we[2], m_stb[2], m_cyc[2];
  logic [3:0]  m_sel[2];
  logic [31:0] m_adr[2], m_wdat[2];
  logic [31:0] m0_rdat, m1_rdat;
  logic        m0_ack, m1_ack, m0_int, m1_int;
  logic        m_ack[2];
  logic [31:0] m_rdat[2];

  logic        s_we, s_stb, s_cyc, s_int, s_ack, s_ack_r, ack_kill;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_wdat, s_rdat;
  logic [1:0]  grant;
  logic        timeout;

  int n_chk = 0;
  int n_fail = 0;
  int wr_cnt = 0;

  assign m_ack[0]  = m0_ack;
  assign m_ack[1]  = m1_ack;
  assign m_rdat[0] = m0_rdat;
  assign m_rdat[1] = m1_rdat;
  assign s_ack     = s_ack_r && !ack_kill;

  wb_bram_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_m0_we(m_we[0]), .i_m0_stb(m_stb[0]), .i_m0_cyc(m_cyc[0]), .i_m0_sel(m_sel[0]),
    .i_m0_adr(m_adr[0]), .i_m0_dat(m_wdat[0]), .o_m0_dat(m0_rdat), .o_m0_ack(m0_ack),
    .o_m0_int(m0_int),
    .i_m1_we(m_we[1]), .i_m1_stb(m_stb[1]), .i_m1_cyc(m_cyc[1]), .i_m1_sel(m_sel[1]),
    .i_m1_adr(m_adr[1]), .i_m1_dat(m_wdat[1]), .o_m1_dat(m1_rdat), .o_m1_ack(m1_ack),
    .o_m1_int(m1_int),
    .o_s_we(s_we), .o_s_stb(s_stb), .o_s_cyc(s_cyc), .o_s_sel(s_sel), .o_s_adr(s_adr),
    .o_s_dat(s_wdat), .i_s_dat(s_rdat), .i_s_ack(s_ack), .i_s_int(s_int),
    .o_grant(grant), .o_timeout(timeout)
  );

  // wb_bram-like slave: registered ack, held until stb falls.
  logic [31:0] mem [256];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ack_r <= 1'b0;
      s_rdat  <= '0;
    end else if (s_cyc && s_stb && !s_ack_r) begin
      s_ack_r <= 1'b1;
      if (s_we) begin
        for (int b = 0; b < 4; b++)
          if (s_sel[b]) mem[s_adr[9:2]][8*b +: 8] <= s_wdat[8*b +: 8];
        wr_cnt <= wr_cnt + 1;
      end else begin
        s_rdat <= mem[s_adr[9:2]];
      end
    end else if (!s_stb) begin
      s_ack_r <= 1'b0;
    end
  end

  // One strobe on master m (cyc is the caller's business); starts and ends #1 after posedge.
  task automatic strobe(input int m, input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, output logic [31:0] rd, output bit ok);
    ok = 0;
    rd = '0;
    m_we[m] = we; m_adr[m] = adr; m_wdat[m] = dat; m_sel[m] = 4'hf; m_stb[m] = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk); #1;
      if (m_ack[m]) begin ok = 1; rd = m_rdat[m]; end
    end
    m_stb[m] = 1'b0;
    m_we[m]  = 1'b0;
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL ack_wait m%0d adr=%h: ack never seen, required 1", m, adr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    n_chk++;
    if ({grant, timeout, s_cyc, s_stb, s_we, m0_ack, m1_ack, s_adr, s_wdat, m0_rdat} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: grant=%b to=%b cyc=%b stb=%b adr=%h, required all 0",
               grant, timeout, s_cyc, s_stb, s_adr);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (grant !== 2'b00) begin n_fail++; $display("FAIL idle_grant: got %b required 00", grant); end
    s_int = 1'b1; #1;
    n_chk++;
    if ({m0_int, m1_int} !== 2'b11) begin
      n_fail++; $display("FAIL int_broadcast: got %b required 11", {m0_int, m1_int});
    end
    s_int = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    logic [31:0] rd;
    bit ok;
    m_cyc[0] = 1'b1;
    strobe(0, 1'b1, 32'h10, 32'h1234_5678, rd, ok);
    n_chk++;
    if (grant !== 2'b01) begin n_fail++; $display("FAIL wr_grant: got %b required 01", grant); end
    strobe(0, 1'b0, 32'h10, 32'h0, rd, ok);
    n_chk++;
    if (rd !== 32'h1234_5678) begin
      n_fail++; $display("FAIL rd_data: got %h required 12345678", rd);
    end
    n_chk++;
    if (m1_ack !== 1'b0) begin n_fail++; $display("FAIL m1_ack_quiet: got %b required 0", m1_ack); end
    m_cyc[0] = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (grant !== 2'b00) begin n_fail++; $display("FAIL wr_release: got %b required 00", grant); end
  endtask

  task automatic test_tie_alternation();
    logic [31:0] rd;
    bit ok;
    rst_n = 1'b0; #2; rst_n = 1'b1;
    @(posedge clk); #1;
    m_cyc[0] = 1'b1; m_cyc[1] = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (grant !== 2'b01) begin n_fail++; $display("FAIL tie_first: got %b required 01", grant); end
    strobe(0, 1'b1, 32'h20, 32'hA5A5_0001, rd, ok);
    m_cyc[0] = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (grant !== 2'b00) begin n_fail++; $display("FAIL tie_dead_cycle: got %b required 00", grant); end
    @(posedge clk); #1;
    n_chk++;
    if (grant !== 2'b10) begin n_fail++; $display("FAIL tie_second: got %b required 10", grant); end
    strobe(1, 1'b1, 32'h24, 32'hA5A5_0002, rd, ok);
    m_cyc[1] = 1'b0;
    @(posedge clk); #1;
    m_cyc[0] = 1'b1; m_cyc[1] = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (grant !== 2'b01) begin n_fail++; $display("FAIL tie_third: got %b required 01", grant); end
    m_cyc[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_chk++;
    if (grant !== 2'b10) begin n_fail++; $display("FAIL tie_fourth: got %b required 10", grant); end
    m_cyc[1] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_no_preempt();
    logic [31:0] rd;
    bit ok;
    m_cyc[1] = 1'b1;
    @(posedge clk); #1;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_adr[0] = 32'h10; m_sel[0] = 4'hf;
    for (int k = 0; k < 3; k++) begin
      strobe(1, 1'b1, 32'h40 + 32'(4*k), 32'hB000_0000 + 32'(k), rd, ok);
      n_chk++;
      if (grant !== 2'b10 || m0_ack !== 1'b0) begin
        n_fail++; $display("FAIL hold_m1[%0d]: grant=%b m0_ack=%b required 10/0", k, grant, m0_ack);
      end
    end
    m_cyc[1] = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (grant !== 2'b00) begin n_fail++; $display("FAIL hold_dead_cycle: got %b required 00", grant); end
    @(posedge clk); #1;
    n_chk++;
    if (grant !== 2'b01) begin n_fail++; $display("FAIL hold_then_m0: got %b required 01", grant); end
    @(posedge clk); #1;
    n_chk++;
    if (m0_ack !== 1'b1 || m0_rdat !== 32'h1234_5678) begin
      n_fail++; $display("FAIL hold_m0_read: ack=%b dat=%h required 1/12345678", m0_ack, m0_rdat);
    end
    m_stb[0] = 1'b0; m_cyc[0] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    ack_kill = 1'b1;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_adr[0] = 32'h10;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      n_chk++;
      if (timeout !== (k == 16) || s_stb !== 1'b1) begin
        n_fail++;
        $display("FAIL to_count[%0d]: timeout=%b s_stb=%b required %b/1", k, timeout, s_stb, k == 16);
      end
    end
    @(posedge clk); #1;
    n_chk++;
    if ({s_stb, s_cyc, m0_ack, timeout, grant} !== 6'b001001 || m0_rdat !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_state: stb=%b cyc=%b ack=%b to=%b grant=%b dat=%h required 0/0/1/0/01/0",
               s_stb, s_cyc, m0_ack, timeout, grant, m0_rdat);
    end
    m_stb[0] = 1'b0; #1;
    n_chk++;
    if (m0_ack !== 1'b0) begin n_fail++; $display("FAIL abort_ack_follow: got %b required 0", m0_ack); end
    m_cyc[0] = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (grant !== 2'b00) begin n_fail++; $display("FAIL abort_exit: got %b required 00", grant); end
    ack_kill = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1; m_adr[1] = 32'h300;
    m_wdat[1] = 32'hCAFE_F00D; m_sel[1] = 4'hf;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_chk++;
    if (grant !== 2'b10 || m1_ack !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre: grant=%b ack=%b required 10/1", grant, m1_ack);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({grant, timeout, s_cyc, s_stb, s_we, m0_ack, m1_ack, s_adr, s_wdat, m1_rdat} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: grant=%b cyc=%b stb=%b we=%b ack=%b adr=%h required all 0",
               grant, s_cyc, s_stb, s_we, m1_ack, s_adr);
    end
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0; m_we[1] = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    m_cyc[0] = 1'b1; m_cyc[1] = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (grant !== 2'b01) begin n_fail++; $display("FAIL post_reset_tie: got %b required 01", grant); end
    m_cyc[0] = 1'b0; m_cyc[1] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [31:0] ref_mem [256];
    bit          ref_vld [256];
    int          n_ok [2];
    int          wr0;
    logic [31:0] rd;
    bit          ok;
    for (int i = 0; i < 256; i++) ref_vld[i] = 0;
    n_ok[0] = 0; n_ok[1] = 0;
    wr0 = wr_cnt;
    fork
      for (int i = 0; i < 100; i++) begin
        logic [31:0] a0, d0, r0;
        bit o0;
        a0 = 32'h100 + 32'(4 * $urandom_range(0, 15));
        d0 = $urandom;
        m_cyc[0] = 1'b1;
        strobe(0, 1'b1, a0, d0, r0, o0);
        if (o0) begin ref_mem[a0[9:2]] = d0; ref_vld[a0[9:2]] = 1; n_ok[0]++; end
        m_cyc[0] = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      for (int j = 0; j < 100; j++) begin
        logic [31:0] a1, d1, r1;
        bit o1;
        a1 = 32'h200 + 32'(4 * $urandom_range(0, 15));
        d1 = $urandom;
        m_cyc[1] = 1'b1;
        strobe(1, 1'b1, a1, d1, r1, o1);
        if (o1) begin ref_mem[a1[9:2]] = d1; ref_vld[a1[9:2]] = 1; n_ok[1]++; end
        m_cyc[1] = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    join
    n_chk++;
    if (n_ok[0] != 100 || n_ok[1] != 100) begin
      n_fail++; $display("FAIL rand_acks: m0=%0d m1=%0d required 100/100", n_ok[0], n_ok[1]);
    end
    n_chk++;
    if (wr_cnt - wr0 != 200) begin
      n_fail++; $display("FAIL rand_slave_writes: got %0d required 200", wr_cnt - wr0);
    end
    for (int w = 64; w < 144; w++) begin
      if (ref_vld[w]) begin
        m_cyc[0] = 1'b1;
        strobe(0, 1'b0, 32'(w) << 2, 32'h0, rd, ok);
        m_cyc[0] = 1'b0;
        @(posedge clk); #1;
        n_chk++;
        if (rd !== ref_mem[w]) begin
          n_fail++; $display("FAIL readback[%h]: got %h required %h", w << 2, rd, ref_mem[w]);
        end
      end
    end
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      m_we[m] = 0; m_stb[m] = 0; m_cyc[m] = 0; m_sel[m] = '0; m_adr[m] = '0; m_wdat[m] = '0;
    end
    s_int = 1'b0;
    ack_kill = 1'b0;
    test_reset();
    test_write_read();
    test_tie_alternation();
    test_no_preempt();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

endmodule
